// File: rtl/anton_neopixel_bus_arbiter_if.sv
// rtl/anton_neopixel_bus_arbiter_if.sv - requester and neopixel bus signals of the two-master arbiter
interface anton_neopixel_bus_arbiter_if #(
   parameter int ADDR_BITS = 14
);
   logic                 req0;
   logic                 req1;
   logic                 write0;
   logic                 write1;
   logic                 lock0;
   logic                 lock1;
   logic [ADDR_BITS-1:0] addr0;
   logic [ADDR_BITS-1:0] addr1;
   logic [7:0]           wdata0;
   logic [7:0]           wdata1;
   logic                 ack0;
   logic                 ack1;
   logic [7:0]           rdata0;
   logic [7:0]           rdata1;
   logic                 busy;
   logic                 grantId;
   logic [ADDR_BITS-1:0] busAddr;
   logic [7:0]           busDataIn;
   logic                 busWrite;
   logic                 busRead;
   logic [7:0]           busDataOut;

   // master: requesters plus the neopixel module's read-data return
   modport master (
      output req0, req1, write0, write1, lock0, lock1,
      output addr0, addr1, wdata0, wdata1, busDataOut,
      input  ack0, ack1, rdata0, rdata1, busy, grantId,
      input  busAddr, busDataIn, busWrite, busRead
   );

   modport slave (
      input  req0, req1, write0, write1, lock0, lock1,
      input  addr0, addr1, wdata0, wdata1, busDataOut,
      output ack0, ack1, rdata0, rdata1, busy, grantId,
      output busAddr, busDataIn, busWrite, busRead
   );
endinterface

// File: rtl/anton_neopixel_bus_arbiter.sv
// rtl/anton_neopixel_bus_arbiter.sv - round-robin/lockable arbiter sharing the neopixel byte bus
// Serialises single-byte accesses from two requesters with a req/ack handshake.
module anton_neopixel_bus_arbiter #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_BITS    = 14
) (
   input logic                      busClk,
   input logic                      busResetN,
   anton_neopixel_bus_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ISSUE   = 2'd1;
   localparam logic [1:0] WAITLAT = 2'd2;
   localparam logic [1:0] ACK     = 2'd3;

   logic [1:0]           state;
   logic                 lastGrant;
   logic                 grantIdR;
   logic                 latWrite;
   logic [ADDR_BITS-1:0] latAddr;
   logic [7:0]           latData;
   logic [2:0]           waitCnt;
   logic [7:0]           rdata0R;
   logic [7:0]           rdata1R;

   logic lockOfLast;
   logic grantNext;

   // Under contention the previous owner keeps the bus only if it holds its lock.
   always_comb begin
      lockOfLast = lastGrant ? bus.lock1 : bus.lock0;
      grantNext  = bus.req1;
      if (bus.req0 && bus.req1)
         grantNext = lockOfLast ? lastGrant : ~lastGrant;
   end

   always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
         state     <= IDLE;
         lastGrant <= 1'b1;
         grantIdR  <= 1'b0;
         latWrite  <= 1'b0;
         latAddr   <= '0;
         latData   <= '0;
         waitCnt   <= '0;
         rdata0R   <= '0;
         rdata1R   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  grantIdR <= grantNext;
                  latWrite <= grantNext ? bus.write1 : bus.write0;
                  latAddr  <= grantNext ? bus.addr1  : bus.addr0;
                  latData  <= grantNext ? bus.wdata1 : bus.wdata0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (latWrite) begin
                  state <= ACK;
               end else begin
                  waitCnt <= 3'(READ_LATENCY);
                  state   <= WAITLAT;
               end
            end
            WAITLAT: begin
               waitCnt <= waitCnt - 3'd1;
               // busDataOut becomes valid READ_LATENCY cycles after the strobe
               if (waitCnt == 3'd1) begin
                  if (grantIdR)
                     rdata1R <= bus.busDataOut;
                  else
                     rdata0R <= bus.busDataOut;
                  state <= ACK;
               end
            end
            ACK: begin
               lastGrant <= grantIdR;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobes, acks and busy decode straight from state so reset clears them at once.
   assign bus.busWrite  = (state == ISSUE) && latWrite;
   assign bus.busRead   = (state == ISSUE) && !latWrite;
   assign bus.ack0      = (state == ACK) && !grantIdR;
   assign bus.ack1      = (state == ACK) && grantIdR;
   assign bus.busy      = (state != IDLE);
   assign bus.grantId   = grantIdR;
   assign bus.busAddr   = latAddr;
   assign bus.busDataIn = latData;
   assign bus.rdata0    = rdata0R;
   assign bus.rdata1    = rdata1R;
endmodule

// File: tb/tb_anton_neopixel_bus_arbiter.sv
// tb/tb_anton_neopixel_bus_arbiter.sv - self-checking bench for anton_neopixel_bus_arbiter
// Directed handshake/reset cases, then randomized traffic against a transaction-level model.
module tb_anton_neopixel_bus_arbiter;
   localparam int AB = 14;
   localparam int RL = 2;

   logic busClk    = 1'b0;
   logic busResetN = 1'b0;
   int   nChecks   = 0;
   int   nPass     = 0;

   anton_neopixel_bus_arbiter_if #(.ADDR_BITS(AB)) bus ();

   anton_neopixel_bus_arbiter #(.READ_LATENCY(RL), .ADDR_BITS(AB)) dut (
      .busClk   (busClk),
      .busResetN(busResetN),
      .bus      (bus)
   );

   always #5 busClk = ~busClk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // neopixel bus slave: byte memory answering READ_LATENCY cycles after busRead
   logic [7:0]    slaveMem [0:(1<<AB)-1];
   logic [7:0]    refMem   [0:(1<<AB)-1];
   int            rdLeft  = 0;
   bit            rdArmed = 1'b0;
   logic [AB-1:0] rdAddr;

   always @(negedge busClk) begin
      if (rdLeft > 0) rdLeft--;
      if (bus.busWrite) slaveMem[bus.busAddr] = bus.busDataIn;
      if (bus.busRead) begin
         rdLeft  = RL;
         rdArmed = 1'b1;
         rdAddr  = bus.busAddr;
      end
      if (rdArmed && rdLeft == 0) begin
         bus.busDataOut = slaveMem[rdAddr];
         rdArmed        = 1'b0;
      end else begin
         bus.busDataOut = 8'($urandom);
      end
   end

   // requester stimulus state
   bit            rq [2];
   bit            wrq[2];
   bit            lk [2];
   bit            granted[2];
   logic [AB-1:0] ad [2];
   logic [7:0]    wd [2];

   task automatic drive();
      bus.req0   = rq[0];  bus.req1   = rq[1];
      bus.write0 = wrq[0]; bus.write1 = wrq[1];
      bus.lock0  = lk[0];  bus.lock1  = lk[1];
      bus.addr0  = ad[0];  bus.addr1  = ad[1];
      bus.wdata0 = wd[0];  bus.wdata1 = wd[1];
   endtask

   task automatic newPayload(input int i, input bit wrOnly);
      wrq[i] = wrOnly ? 1'b1 : 1'($urandom_range(1));
      ad[i]  = AB'(32'h100 + $urandom_range(15));
      wd[i]  = 8'($urandom);
   endtask

   // transaction-level reference: each access occupies [issue, ack] and the bus is free after
   typedef struct {
      bit            valid;
      bit            who;
      bit            wr;
      logic [AB-1:0] addr;
      logic [7:0]    data;
      int            issue;
      int            ack;
      logic [7:0]    rexp;
   } txn_t;

   txn_t       tr;
   int         n;
   int         freeAt;
   bit         last;
   logic [7:0] expR[2];
   int         ackLog[$];

   task automatic runCycles(input int cycles, input int pRaise, input int pKeep,
                            input int lockMode, input bit wrOnly, input bit scramble);
      bit inIssue, inAck, who;
      for (int k = 0; k < cycles; k++) begin
         @(negedge busClk);
         n++;
         inIssue = tr.valid && n == tr.issue;
         inAck   = tr.valid && n == tr.ack;
         if (inAck && !tr.wr) expR[tr.who] = tr.rexp;
         check("m.busy",     32'(bus.busy),     32'(tr.valid && n >= tr.issue && n <= tr.ack));
         check("m.busWrite", 32'(bus.busWrite), 32'(inIssue && tr.wr));
         check("m.busRead",  32'(bus.busRead),  32'(inIssue && !tr.wr));
         check("m.ack0",     32'(bus.ack0),     32'(inAck && !tr.who));
         check("m.ack1",     32'(bus.ack1),     32'(inAck && tr.who));
         check("m.rdata0",   32'(bus.rdata0),   32'(expR[0]));
         check("m.rdata1",   32'(bus.rdata1),   32'(expR[1]));
         if (inIssue) begin
            check("m.busAddr", 32'(bus.busAddr), 32'(tr.addr));
            check("m.grantId", 32'(bus.grantId), 32'(tr.who));
            if (tr.wr) check("m.busDataIn", 32'(bus.busDataIn), 32'(tr.data));
         end
         if (bus.ack0) ackLog.push_back(0);
         if (bus.ack1) ackLog.push_back(1);

         for (int i = 0; i < 2; i++) begin
            if (inAck && tr.who == 1'(i)) begin
               granted[i] = 1'b0;
               if (rq[i] && $urandom_range(99) < pKeep) newPayload(i, wrOnly);
               else rq[i] = 1'b0;
            end else if (!rq[i]) begin
               if ($urandom_range(99) < pRaise) begin
                  rq[i] = 1'b1;
                  newPayload(i, wrOnly);
               end
            end else if (granted[i] && scramble) begin
               if ($urandom_range(3) == 0) begin
                  ad[i] = AB'($urandom);
                  wd[i] = 8'($urandom);
               end
               if ($urandom_range(7) == 0) rq[i] = 1'b0;
            end
            case (lockMode)
               0:       if ($urandom_range(15) == 0) lk[i] = !lk[i];
               1:       lk[i] = (i == 1);
               default: lk[i] = 1'b0;
            endcase
         end
         drive();

         if (n >= freeAt && (rq[0] || rq[1])) begin
            if (rq[0] && rq[1]) who = lk[last] ? last : !last;
            else                who = rq[1];
            tr.valid = 1'b1;
            tr.who   = who;
            tr.wr    = wrq[who];
            tr.addr  = ad[who];
            tr.data  = wd[who];
            tr.issue = n + 1;
            tr.ack   = n + 2 + (tr.wr ? 0 : RL);
            freeAt   = tr.ack + 1;
            if (tr.wr) refMem[tr.addr] = tr.data;
            else       tr.rexp = refMem[tr.addr];
            last        = who;
            granted[who] = 1'b1;
         end
      end
   endtask

   task automatic clearReqs();
      for (int i = 0; i < 2; i++) begin
         rq[i] = 1'b0; wrq[i] = 1'b0; lk[i] = 1'b0; granted[i] = 1'b0;
         ad[i] = '0;   wd[i] = '0;
      end
      drive();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

   initial begin
      int lat, nAck, c0, c1;
      bit found;
      for (int a = 0; a < (1 << AB); a++) begin
         slaveMem[a] = 8'h00;
         refMem[a]   = 8'h00;
      end
      clearReqs();
      busResetN = 1'b0;
      repeat (3) @(negedge busClk);
      check("rst.busy",      32'(bus.busy),      0);
      check("rst.busWrite",  32'(bus.busWrite),  0);
      check("rst.busRead",   32'(bus.busRead),   0);
      check("rst.ack0",      32'(bus.ack0),      0);
      check("rst.ack1",      32'(bus.ack1),      0);
      check("rst.grantId",   32'(bus.grantId),   0);
      check("rst.busAddr",   32'(bus.busAddr),   0);
      check("rst.busDataIn", 32'(bus.busDataIn), 0);
      check("rst.rdata0",    32'(bus.rdata0),    0);
      check("rst.rdata1",    32'(bus.rdata1),    0);
      busResetN = 1'b1;

      // single write, payload disturbed during ISSUE
      @(negedge busClk);
      rq[0] = 1'b1; wrq[0] = 1'b1; ad[0] = 14'h0002; wd[0] = 8'hA5; drive();
      @(negedge busClk);
      check("wr.busWrite",  32'(bus.busWrite),  1);
      check("wr.busRead",   32'(bus.busRead),   0);
      check("wr.busAddr",   32'(bus.busAddr),   32'h0002);
      check("wr.busDataIn", 32'(bus.busDataIn), 32'hA5);
      check("wr.grantId",   32'(bus.grantId),   0);
      ad[0] = 14'h3FFF; wd[0] = 8'h5A; drive();
      #1;
      check("wr.latAddr", 32'(bus.busAddr),   32'h0002);
      check("wr.latData", 32'(bus.busDataIn), 32'hA5);
      @(negedge busClk);
      check("wr.ack0",     32'(bus.ack0),     1);
      check("wr.ack1",     32'(bus.ack1),     0);
      check("wr.busWrite", 32'(bus.busWrite), 0);
      rq[0] = 1'b0; drive();
      @(negedge busClk);
      check("wr.ackPulse", 32'(bus.ack0), 0);
      check("wr.idle",     32'(bus.busy), 0);

      // read on requester 1
      slaveMem[14'h0010] = 8'h3C;
      rq[1] = 1'b1; wrq[1] = 1'b0; ad[1] = 14'h0010; drive();
      found = 1'b0; lat = 0;
      for (int k = 1; k <= 8 && !found; k++) begin
         @(negedge busClk);
         if (k == 1) check("rd.busRead", 32'(bus.busRead), 1);
         check("rd.noAck0", 32'(bus.ack0), 0);
         if (bus.ack1) begin found = 1'b1; lat = k; end
      end
      check("rd.ackLatency", 32'(lat),        32'(2 + RL));
      check("rd.rdata1",     32'(bus.rdata1), 32'h3C);
      check("rd.rdata0",     32'(bus.rdata0), 0);
      rq[1] = 1'b0; drive();
      @(negedge busClk);

      // reset while the read waits for data
      slaveMem[14'h0020] = 8'h77;
      rq[0] = 1'b1; wrq[0] = 1'b0; ad[0] = 14'h0020; drive();
      @(negedge busClk);
      check("ab.busRead", 32'(bus.busRead), 1);
      @(negedge busClk);
      check("ab.waitBusy", 32'(bus.busy), 1);
      #2 busResetN = 1'b0;
      #1;
      check("ab.busy",    32'(bus.busy),    0);
      check("ab.busRead", 32'(bus.busRead), 0);
      check("ab.ack0",    32'(bus.ack0),    0);
      check("ab.rdata1",  32'(bus.rdata1),  0);
      rq[0] = 1'b0; drive();
      @(negedge busClk);
      busResetN = 1'b1;
      nAck = 0;
      repeat (6) begin
         @(negedge busClk);
         if (bus.ack0 || bus.ack1) nAck++;
      end
      check("ab.noAck", 32'(nAck), 0);
      rq[0] = 1'b1; drive();
      found = 1'b0; lat = 0;
      for (int k = 1; k <= 8 && !found; k++) begin
         @(negedge busClk);
         if (bus.ack0) begin found = 1'b1; lat = k; end
      end
      check("ab.reReadLatency", 32'(lat),        32'(2 + RL));
      check("ab.reReadData",    32'(bus.rdata0), 32'h77);
      rq[0] = 1'b0; drive();

      // model-checked phases start from a fresh reset
      for (int a = 0; a < 16; a++) begin
         slaveMem[14'h100 + a] = 8'($urandom);
         refMem[14'h100 + a]   = slaveMem[14'h100 + a];
      end
      @(negedge busClk);
      busResetN = 1'b0;
      clearReqs();
      @(negedge busClk);
      busResetN = 1'b1;
      n = 0; freeAt = 0; tr.valid = 1'b0; last = 1'b1;
      expR[0] = 8'h00; expR[1] = 8'h00;

      ackLog.delete();
      runCycles(12, 100, 100, 2, 1'b1, 1'b0);
      check("alt.count", 32'(ackLog.size()), 4);
      for (int i = 0; i < 4; i++)
         check("alt.order", 32'((i < ackLog.size()) ? ackLog[i] : 99), 32'(i % 2));

      ackLog.delete();
      runCycles(30, 100, 100, 1, 1'b1, 1'b0);
      c0 = 0; c1 = 0;
      foreach (ackLog[i]) if (ackLog[i] == 0) c0++; else c1++;
      check("lock.acks0", 32'(c0), 0);
      check("lock.acks1", 32'(c1), 10);

      ackLog.delete();
      runCycles(6, 100, 100, 2, 1'b1, 1'b0);
      check("unlock.first", 32'((ackLog.size() > 0) ? ackLog[0] : 99), 0);

      runCycles(3000, 30, 50, 0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule

// File: doc/anton_neopixel_bus_arbiter.md
Name: anton_neopixel_bus_arbiter

Overview:
- Shares the neopixel register/pixel bus (busAddr/busDataIn/busWrite/busRead/busDataOut) between two masters: requester 0 (CPU/MSS bridge) and requester 1 (animation/DMA engine).
- Serialises single-byte accesses with a req/ack handshake.
- Round-robin on contention; a per-requester lock allows uninterrupted bursts, e.g. a full pixel frame.
- Sits directly in front of anton_neopixel_module and drives its bus pins.

Parameters:
- READ_LATENCY, 1, busClk cycles from the busRead strobe until busDataOut is valid. Legal range 1..4.
- ADDR_BITS, 14, bus address width; must match the neopixel bus.

Ports:
- busClk  input  1  single clock for all logic.
- busResetN  input  1  asynchronous active-low reset.
- req0, req1  input  1 each  access request, held until ack.
- write0, write1  input  1 each  1 = write, 0 = read; sampled at grant.
- lock0, lock1  input  1 each  keep priority for back-to-back accesses.
- addr0, addr1  input  ADDR_BITS each  access address.
- wdata0, wdata1  input  8 each  write data.
- ack0, ack1  output  1 each  one-cycle completion pulse.
- rdata0, rdata1  output  8 each  read data; valid from the ack cycle.
- busy  output  1  high whenever the FSM is not IDLE.
- grantId  output  1  requester owning the current or last access.
- busAddr  output  ADDR_BITS  to the neopixel module.
- busDataIn  output  8  write data to the neopixel module.
- busWrite, busRead  output  1 each  strobes to the neopixel module.
- busDataOut  input  8  read data from the neopixel module.

Behaviour:
- Clock/reset: one clock (busClk); reset is asynchronous, active-low (busResetN).
- Reset values: all outputs 0, FSM = IDLE, lastGrant = 1 (so requester 0 wins the first tie), wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE, no req: stay in IDLE; strobes low.
- IDLE, exactly one req: grant it.
- IDLE, both req: if lock of lastGrant is high, regrant lastGrant; otherwise grant the requester that is not lastGrant.
- On grant: latch addr, wdata, write and grant id into internal registers; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - busAddr/busDataIn are driven from the latches.
  - write: busWrite = 1, then go to ACK.
  - read: busRead = 1, load the counter with READ_LATENCY, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 1, register busDataOut into rdataN of the granted requester, then go to ACK.
- ACK (1 cycle): ackN = 1 for the granted requester only; lastGrant = grant id; go to IDLE.
- busAddr/busDataIn hold their last values outside ISSUE. busWrite and busRead are never both high and are each high only in ISSUE.
- Latency, req first seen in IDLE at cycle t:
  - write: busWrite at t+1, ack at t+2.
  - read: busRead at t+1, ack at t+2+READ_LATENCY.
  - Minimum back-to-back spacing: 3 cycles for writes, 3+READ_LATENCY for reads.
- Handshake rules:
  - Requester holds req and its payload stable until ack.
  - Payload changes after grant are ignored (latched).
  - If req is still high in the cycle after ack, it is treated as a new request.
  - Dropping req before ack does not abort the access; the ack is still issued.
- rdataN holds its value until that requester's next read ack. Write acks do not modify rdataN.
- Lock:
  - Lock is only evaluated in IDLE under contention.
  - lock0 and lock1 both high: lastGrant keeps priority.
  - With lock held continuously, the locked requester starves the other. This is intended (frame bursts).
- Reset asserted mid-access: strobes, ack and busy drop to 0 immediately (async). No ack is issued for the aborted access. Restart from IDLE with lastGrant = 1.
- Address arithmetic: none. Addresses pass through unchanged.

Test Plan:
- Reset, then req0 write addr=0x0002 wdata=0xA5 -> busWrite=1 with busAddr=0x0002, busDataIn=0xA5 exactly one cycle later; ack0 the following cycle; ack1 never asserted.
- READ_LATENCY=2; req1 read addr=0x0010; model returns 0x3C two cycles after busRead -> ack1 at t+4, rdata1=0x3C; rdata0 unchanged.
- req0 and req1 held high continuously with writes, no lock -> grants alternate 0,1,0,1; first grant is 0 after reset; 4 accesses complete in 12 cycles.
- lock1=1 with req0 and req1 both held -> after requester 1's first access, every subsequent grant goes to 1. Release lock1 -> next grant goes to 0.
- Assert busResetN=0 during WAIT of a read -> busRead/busy/ack go 0 asynchronously. After release, a new req0 read completes normally and the aborted read produces no ack.
- Change addr0 and wdata0 during ISSUE -> bus shows the originally latched values; the ack still arrives at t+2.
